ram_port_arbiter: RTL and testbench
===================================

# ram_port_arbiter

Sequential arbiter that shares the single RAM port between the per-CPU instruction fetch ports and the coherence bus master. The bus master reads and writes cache blocks for the data caches and gets fixed priority. Instruction requesters are served round-robin, with an optional starvation guard. The block sits between the coherence controller and the RAM model and owns every RAM strobe.

## Interface
- CPUS, 2: number of instruction requesters; must be ≥2.
- STARVE_LIMIT, 4: consecutive bus grants allowed while any iREN is pending. Used only with the starvation guard.
- CLK  in  1  clock, rising edge.
- nRST  in  1  reset, asynchronous, active-low.
- iREN  in  CPUS  instruction read request, one bit per CPU.
- iaddr  in  CPUS×32  instruction word address, one per CPU.
- iwait  out  CPUS  low only in the cycle the requester's word completes.
- iload  out  CPUS×32  ramload when the matching iwait is low, else 0.
- bREN  in  1  bus master read request.
- bWEN  in  1  bus master write request.
- bLOCK  in  1  keeps the bus grant across word completions; used for two-word block transfers.
- baddr  in  32  bus master word address.
- bstore  in  32  bus master write data.
- bwait  out  1  low only in the bus master's completing cycle.
- bload  out  32  ramload when bwait is low, else 0.
- ramREN  out  1  RAM read strobe.
- ramWEN  out  1  RAM write strobe.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3.

## Operation
- **States and registers:**
  - States: IDLE, GNT_I, GNT_B.
  - Registers: owner index `own` ($clog2(CPUS) bits), round-robin pointer `rr`, bus-grant counter `bcnt` ($clog2(STARVE_LIMIT+1) bits).
- **IDLE:**
  - RAM strobes are 0.
  - Arbitration: if bREN|bWEN, go to GNT_B. Otherwise, if any iREN, pick the first set bit searching from `rr` upward with wrap CPUS-1→0, load `own`, and go to GNT_I.
  - No request: stay in IDLE.
- **GNT_I:**
  - ramREN=iREN[own], ramaddr=iaddr[own], ramWEN=0.
  - On ramstate==ACCESS: iwait[own]=0, `rr`=own+1 mod CPUS, then re-arbitrate in the same cycle with IDLE rules. Any pending request goes directly to its grant state with no idle bubble.
  - iREN[own] dropped before ACCESS: abort, strobes go to 0 that cycle, next state IDLE, `rr` unchanged.
- **GNT_B:**
  - ramWEN=bWEN, ramREN=bREN&~bWEN (bWEN wins if both are set), ramaddr=baddr, ramstore=bstore.
  - On ACCESS: bwait=0. If bLOCK is high, stay in GNT_B; otherwise re-arbitrate.
  - bREN and bWEN both dropped: abort to IDLE.
- ramstate ERROR or BUSY: hold the grant, waits stay high.
- ramstore=0 whenever the state is not GNT_B.
- **bcnt:**
  - Increments on each bus completion without bLOCK while any iREN is high, saturating at STARVE_LIMIT.
  - Clears on any instruction completion or when no iREN is pending.

## Timing
- Reset values:
  - State IDLE; own, rr and bcnt are 0.
  - iwait all 1, bwait 1.
  - ramREN, ramWEN, ramaddr, ramstore are 0.
  - iload and bload are 0.
- Latency: request first seen in IDLE at cycle t → strobes asserted at t+1. ACCESS at cycle k → wait low and load valid in cycle k. The next owner's strobes are asserted at k+1.
- Handshake: requesters hold REN/WEN, address and data stable until their wait goes low. A one-cycle wait pulse completes exactly one word.
- Simultaneous bus and instruction requests at arbitration: the bus wins, except as given under Configuration.
- Reset mid-grant: the grant is dropped immediately, all outputs take reset values asynchronously, and no partial completion is reported.

## Configuration
- ARB_STARVE_GUARD_EN defined: at arbitration with bcnt==STARVE_LIMIT and any iREN pending, the instruction requester wins over the bus. bcnt clears when that instruction completion occurs.
- ARB_STARVE_GUARD_EN undefined: strict bus priority. bcnt and STARVE_LIMIT logic are not compiled, and the bus can starve instruction fetch indefinitely.

## Test plan
- **Reset and first fetch:** iREN=01, iaddr[0]=0x100, RAM ACCESS after 2 BUSY cycles. Required: ramREN at t+1, iwait[0] low for exactly one cycle, iload[0]=ramload, iwait[1] stays 1.
- **Round-robin:** iREN=11 held continuously, ACCESS every 2nd cycle. Grants alternate 0,1,0,1; rr wraps from 1 to 0; no IDLE cycle between grants.
- **Bus priority:** bREN and iREN[1] asserted in the same cycle. Bus is granted first with ramaddr=baddr; the icache is granted at the cycle after the bus ACCESS.
- **Locked block write:** bWEN=1, bLOCK=1, baddr 0x200 then 0x204. Two ramWEN words are written with no icache grant in between. With bREN=bWEN=1, ramREN=0.
- **Starvation guard (EN defined, STARVE_LIMIT=4):** bREN held, iREN[0] held, bLOCK=0. After 4 bus completions the 5th grant goes to CPU0. With the macro undefined, CPU0 is never granted.
- **Abort and async reset:** iREN[0] dropped while BUSY → strobes 0 the same cycle, next state IDLE. nRST asserted mid-GNT_B → bwait=1 and ramWEN=0 immediately.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Shares the single RAM port between per-CPU instruction fetch and the coherence bus master.
// Define ARB_STARVE_GUARD_EN to let a starved instruction fetch win after STARVE_LIMIT bus grants.
module ram_port_arbiter #(
    parameter int CPUS         = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic [CPUS-1:0]       iREN,
    input  logic [CPUS-1:0][31:0] iaddr,
    output logic [CPUS-1:0]       iwait,
    output logic [CPUS-1:0][31:0] iload,
    input  logic                  bREN,
    input  logic                  bWEN,
    input  logic                  bLOCK,
    input  logic [31:0]           baddr,
    input  logic [31:0]           bstore,
    output logic                  bwait,
    output logic [31:0]           bload,
    output logic                  ramREN,
    output logic                  ramWEN,
    output logic [31:0]           ramaddr,
    output logic [31:0]           ramstore,
    input  logic [31:0]           ramload,
    input  logic [1:0]            ramstate
);
    localparam int         IW         = $clog2(CPUS);
    localparam logic [1:0] RAM_ACCESS = 2'd2;

    typedef enum logic [1:0] {IDLE, GNT_I, GNT_B} state_t;

    state_t        state, state_nxt;
    logic [IW-1:0] own, own_nxt, rr, rr_nxt, own_inc, pick, cand;
    logic          pick_found, access, i_done, b_done, bus_req, i_first, arb;

    assign access  = (ramstate == RAM_ACCESS);
    assign i_done  = (state == GNT_I) && access;
    assign b_done  = (state == GNT_B) && access;
    assign bus_req = bREN | bWEN;
    assign own_inc = (own == IW'(CPUS - 1)) ? '0 : own + 1'b1;
    assign rr_nxt  = i_done ? own_inc : rr;

    // Scan downward so the last hit is the nearest set bit at or after rr_nxt.
    always_comb begin
        pick_found = 1'b0;
        pick       = '0;
        cand       = '0;
        for (int k = CPUS - 1; k >= 0; k--) begin
            cand = IW'((int'(rr_nxt) + k) % CPUS);
            if (iREN[cand]) begin
                pick_found = 1'b1;
                pick       = cand;
            end
        end
    end

`ifdef ARB_STARVE_GUARD_EN
    localparam int BW = $clog2(STARVE_LIMIT + 1);
    logic [BW-1:0] bcnt, bcnt_nxt;

    always_comb begin
        bcnt_nxt = bcnt;
        if (!(|iREN) || i_done)
            bcnt_nxt = '0;
        else if (b_done && !bLOCK && (bcnt != BW'(STARVE_LIMIT)))
            bcnt_nxt = bcnt + 1'b1;
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) bcnt <= '0;
        else       bcnt <= bcnt_nxt;
    end

    // The completion being counted this cycle already counts toward the limit.
    assign i_first = (bcnt_nxt == BW'(STARVE_LIMIT));
`else
    assign i_first = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state <= IDLE;
            own   <= '0;
            rr    <= '0;
        end else begin
            state <= state_nxt;
            own   <= own_nxt;
            rr    <= rr_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        own_nxt   = own;
        arb       = 1'b0;
        case (state)
            IDLE:    arb = 1'b1;
            GNT_I: begin
                if (access)          arb = 1'b1;
                else if (!iREN[own]) state_nxt = IDLE;
            end
            GNT_B: begin
                if (access)          arb = !bLOCK;
                else if (!bus_req)   state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (arb) begin
            if (pick_found && (i_first || !bus_req)) begin
                state_nxt = GNT_I;
                own_nxt   = pick;
            end else if (bus_req) begin
                state_nxt = GNT_B;
            end else begin
                state_nxt = IDLE;
            end
        end
    end

    always_comb begin
        iwait    = '1;
        iload    = '0;
        bwait    = 1'b1;
        bload    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        case (state)
            GNT_I: begin
                ramREN  = iREN[own];
                ramaddr = iaddr[own];
                if (access) begin
                    iwait[own] = 1'b0;
                    iload[own] = ramload;
                end
            end
            GNT_B: begin
                ramWEN   = bWEN;
                ramREN   = bREN & ~bWEN;
                ramaddr  = baddr;
                ramstore = bstore;
                if (access) begin
                    bwait = 1'b0;
                    bload = ramload;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: a cycle table plus hand-written corner sequences.
// Follows ARB_STARVE_GUARD_EN to pick the expected starvation behaviour.
module tb_ram_port_arbiter;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACC = 2'd2, ERR = 3;

    logic             CLK = 1'b0;
    logic             nRST = 1'b0;
    logic [1:0]       iREN;
    logic [1:0][31:0] iaddr;
    logic [1:0]       iwait;
    logic [1:0][31:0] iload;
    logic             bREN, bWEN, bLOCK;
    logic [31:0]      baddr, bstore, bload;
    logic             bwait;
    logic             ramREN, ramWEN;
    logic [31:0]      ramaddr, ramstore, ramload;
    logic [1:0]       ramstate;

    int total = 0;
    int bad   = 0;

    ram_port_arbiter #(.CPUS(2), .STARVE_LIMIT(4)) dut (
        .CLK(CLK), .nRST(nRST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .bREN(bREN), .bWEN(bWEN), .bLOCK(bLOCK), .baddr(baddr), .bstore(bstore),
        .bwait(bwait), .bload(bload),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [1:0]  iren;
        logic        bren;
        logic        bwen;
        logic        blk;
        logic [31:0] baddr;
        logic [31:0] bstore;
        logic [1:0]  rs;
        logic        late;
        logic [1:0]  iren_late;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic [1:0]  e_iwait;
        logic        e_bwait;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic [1:0] iren, input logic bren, input logic bwen,
                                input logic blk, input logic [31:0] ba, input logic [31:0] bs,
                                input logic [1:0] rs, input logic late, input logic [1:0] iren_late,
                                input logic e_ren, input logic e_wen, input logic [31:0] e_addr,
                                input logic [31:0] e_store, input logic [1:0] e_iwait,
                                input logic e_bwait);
        vec_t v;
        v.iren = iren; v.bren = bren; v.bwen = bwen; v.blk = blk;
        v.baddr = ba; v.bstore = bs; v.rs = rs; v.late = late; v.iren_late = iren_late;
        v.e_ren = e_ren; v.e_wen = e_wen; v.e_addr = e_addr; v.e_store = e_store;
        v.e_iwait = e_iwait; v.e_bwait = e_bwait;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic e_ren, input logic e_wen,
                             input logic [31:0] e_addr, input logic [31:0] e_store,
                             input logic [1:0] e_iwait, input logic e_bwait);
        logic [1:0][31:0] e_iload;
        e_iload[0] = e_iwait[0] ? 32'h0 : ramload;
        e_iload[1] = e_iwait[1] ? 32'h0 : ramload;
        check({tag, " ramREN"},   64'(ramREN),   64'(e_ren));
        check({tag, " ramWEN"},   64'(ramWEN),   64'(e_wen));
        check({tag, " ramaddr"},  64'(ramaddr),  64'(e_addr));
        check({tag, " ramstore"}, 64'(ramstore), 64'(e_store));
        check({tag, " iwait"},    64'(iwait),    64'(e_iwait));
        check({tag, " bwait"},    64'(bwait),    64'(e_bwait));
        check({tag, " iload"},    64'(iload),    64'(e_iload));
        check({tag, " bload"},    64'(bload),    64'(e_bwait ? 32'h0 : ramload));
    endtask

    task automatic idle_inputs();
        iREN = 2'b00; bREN = 1'b0; bWEN = 1'b0; bLOCK = 1'b0;
        baddr = 32'h0; bstore = 32'h0; ramstate = FREE; ramload = 32'h0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        nRST = 1'b0;
        idle_inputs();
        repeat (2) @(posedge CLK);
        #1 nRST = 1'b1;
    endtask

    initial begin
        int bus_n, i_n, first_i;

        iaddr[0] = 32'h100;
        iaddr[1] = 32'h180;
        //               iren  bR bW bL baddr        bstore        rs   lt late  ren wen addr         store         iwait  bw
        tbl[0]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        FREE, 0, 2'b00, 0, 0, 32'h0,       32'h0,        2'b11, 1);
        tbl[1]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        BUSY, 0, 2'b00, 1, 0, 32'h100,     32'h0,        2'b11, 1);
        tbl[2]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        ACC,  0, 2'b00, 1, 0, 32'h100,     32'h0,        2'b10, 1);
        tbl[3]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        BUSY, 0, 2'b00, 1, 0, 32'h180,     32'h0,        2'b11, 1);
        tbl[4]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        ACC,  0, 2'b00, 1, 0, 32'h180,     32'h0,        2'b01, 1);
        tbl[5]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        BUSY, 0, 2'b00, 1, 0, 32'h100,     32'h0,        2'b11, 1);
        tbl[6]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        ACC,  0, 2'b00, 1, 0, 32'h100,     32'h0,        2'b10, 1);
        tbl[7]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        ERR,  0, 2'b00, 1, 0, 32'h180,     32'h0,        2'b11, 1);
        tbl[8]  = mk(2'b11, 0, 0, 0, 32'h0,       32'h0,        ACC,  1, 2'b00, 1, 0, 32'h180,     32'h0,        2'b01, 1);
        tbl[9]  = mk(2'b10, 1, 0, 0, 32'h300,     32'hDEAD0000, FREE, 0, 2'b00, 0, 0, 32'h0,       32'h0,        2'b11, 1);
        tbl[10] = mk(2'b10, 1, 0, 0, 32'h300,     32'hDEAD0000, BUSY, 0, 2'b00, 1, 0, 32'h300,     32'hDEAD0000, 2'b11, 1);
        tbl[11] = mk(2'b10, 1, 0, 0, 32'h300,     32'hDEAD0000, ACC,  1, 2'b10, 1, 0, 32'h300,     32'hDEAD0000, 2'b11, 0);
        tbl[12] = mk(2'b10, 0, 0, 0, 32'h300,     32'hDEAD0000, BUSY, 0, 2'b00, 1, 0, 32'h180,     32'h0,        2'b11, 1);
        tbl[13] = mk(2'b10, 0, 0, 0, 32'h300,     32'hDEAD0000, ACC,  1, 2'b00, 1, 0, 32'h180,     32'h0,        2'b01, 1);
        tbl[14] = mk(2'b01, 1, 1, 1, 32'h200,     32'hCAFE0001, FREE, 0, 2'b00, 0, 0, 32'h0,       32'h0,        2'b11, 1);
        tbl[15] = mk(2'b01, 1, 1, 1, 32'h200,     32'hCAFE0001, BUSY, 0, 2'b00, 0, 1, 32'h200,     32'hCAFE0001, 2'b11, 1);
        tbl[16] = mk(2'b01, 1, 1, 1, 32'h200,     32'hCAFE0001, ACC,  0, 2'b00, 0, 1, 32'h200,     32'hCAFE0001, 2'b11, 0);
        tbl[17] = mk(2'b01, 1, 1, 1, 32'h204,     32'hCAFE0002, BUSY, 0, 2'b00, 0, 1, 32'h204,     32'hCAFE0002, 2'b11, 1);
        tbl[18] = mk(2'b01, 1, 1, 0, 32'h204,     32'hCAFE0002, ACC,  1, 2'b01, 0, 1, 32'h204,     32'hCAFE0002, 2'b11, 0);
        tbl[19] = mk(2'b01, 0, 0, 0, 32'h204,     32'hCAFE0002, BUSY, 0, 2'b00, 1, 0, 32'h100,     32'h0,        2'b11, 1);
        tbl[20] = mk(2'b01, 0, 0, 0, 32'h204,     32'hCAFE0002, ACC,  1, 2'b00, 1, 0, 32'h100,     32'h0,        2'b10, 1);
        tbl[21] = mk(2'b00, 0, 0, 0, 32'h0,       32'h0,        FREE, 0, 2'b00, 0, 0, 32'h0,       32'h0,        2'b11, 1);

        // Requests asserted while reset is held must not reach the outputs.
        idle_inputs();
        iREN = 2'b11; bREN = 1'b1; bWEN = 1'b1; ramstate = ACC; ramload = 32'hFFFF_FFFF;
        repeat (2) @(posedge CLK);
        #1 check_all("reset", 0, 0, 32'h0, 32'h0, 2'b11, 1);

        do_reset();
        for (int i = 0; i < 22; i++) begin
            iREN = tbl[i].iren; bREN = tbl[i].bren; bWEN = tbl[i].bwen; bLOCK = tbl[i].blk;
            baddr = tbl[i].baddr; bstore = tbl[i].bstore; ramstate = tbl[i].rs;
            ramload = 32'h1000_0000 + 32'(i);
            #2;
            check_all($sformatf("v%0d", i), tbl[i].e_ren, tbl[i].e_wen, tbl[i].e_addr,
                      tbl[i].e_store, tbl[i].e_iwait, tbl[i].e_bwait);
            if (tbl[i].late) begin
                #1;
                bREN = 1'b0; bWEN = 1'b0; iREN = tbl[i].iren_late;
            end
            tick();
        end

        // Bus held with unlocked completions every cycle while CPU0 waits.
        do_reset();
        iREN = 2'b01; bREN = 1'b1; baddr = 32'h500; ramstate = ACC; ramload = 32'h5555;
        bus_n = 0; i_n = 0; first_i = -1;
        for (int c = 0; c < 21; c++) begin
            #2;
            if (!bwait) bus_n++;
            if (!iwait[0]) begin
                if (first_i < 0) first_i = bus_n;
                i_n++;
            end
            tick();
        end
`ifdef ARB_STARVE_GUARD_EN
        check("starve bus_before_first_i", 64'(first_i), 64'd4);
        check("starve i_completions", 64'(i_n), 64'd4);
        check("starve bus_completions", 64'(bus_n), 64'd16);
`else
        check("starve i_completions", 64'(i_n), 64'd0);
        check("starve bus_completions", 64'(bus_n), 64'd20);
`endif

        // First fetch: two BUSY cycles then ACCESS.
        do_reset();
        iREN = 2'b01; ramload = 32'h0BAD_F00D;
        #2 check_all("ff0", 0, 0, 32'h0, 32'h0, 2'b11, 1);
        tick(); ramstate = BUSY;
        #2 check_all("ff1", 1, 0, 32'h100, 32'h0, 2'b11, 1);
        tick();
        #2 check_all("ff2", 1, 0, 32'h100, 32'h0, 2'b11, 1);
        tick(); ramstate = ACC;
        #2 check_all("ff3", 1, 0, 32'h100, 32'h0, 2'b10, 1);
        #1 iREN = 2'b00;
        tick(); ramstate = FREE;
        #2 check_all("ff4", 0, 0, 32'h0, 32'h0, 2'b11, 1);

        // Abort: CPU0 drops its request while the RAM is busy.
        tick(); iREN = 2'b01; ramstate = BUSY;
        #2 check_all("ab0", 0, 0, 32'h0, 32'h0, 2'b11, 1);
        tick();
        #2 check_all("ab1", 1, 0, 32'h100, 32'h0, 2'b11, 1);
        tick(); iREN = 2'b00;
        #2 check_all("ab2", 0, 0, 32'h100, 32'h0, 2'b11, 1);
        tick(); iREN = 2'b01;
        #2 check_all("ab3", 0, 0, 32'h0, 32'h0, 2'b11, 1);
        tick();
        #2 check_all("ab4", 1, 0, 32'h100, 32'h0, 2'b11, 1);

        // Asynchronous reset in the middle of a bus write grant.
        tick(); iREN = 2'b00; bWEN = 1'b1; baddr = 32'h400; bstore = 32'h77;
        #2 check_all("rs0", 0, 0, 32'h100, 32'h0, 2'b11, 1);
        tick();
        #2 check_all("rs1", 0, 0, 32'h0, 32'h0, 2'b11, 1);
        tick(); ramstate = ACC; ramload = 32'h4444;
        #2 check_all("rs2", 0, 1, 32'h400, 32'h77, 2'b11, 0);
        #1 nRST = 1'b0;
        #1 check_all("rs3", 0, 0, 32'h0, 32'h0, 2'b11, 1);
        tick();
        idle_inputs();
        nRST = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
